// File: rtl/ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ex_operand_stage
//  Brief    : ID/EX pipeline register with RAW forwarding, ALUSrc operand
//             select, load-use bubble insertion, downstream hold and flush.
//  Revision : 1.0 - initial release
// ============================================================================
module ex_operand_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [6:0]      id_opcode,
    input  logic [2:0]      id_func3,
    input  logic [RA_W-1:0] id_rs1_addr,
    input  logic [RA_W-1:0] id_rs2_addr,
    input  logic [RA_W-1:0] id_rd_addr,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_alu_src,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            stall_in,
    input  logic            flush,
    input  logic            exmem_reg_write,
    input  logic [RA_W-1:0] exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_reg_write,
    input  logic [RA_W-1:0] memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
    output logic            ex_valid,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_func3,
    output logic [RA_W-1:0] ex_rd_addr,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic [XLEN-1:0] ex_store_data,
    output logic            id_stall
);

    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;

    logic            r_valid;
    logic [6:0]      r_opcode;
    logic [2:0]      r_func3;
    logic [RA_W-1:0] r_rs1_addr;
    logic [RA_W-1:0] r_rs2_addr;
    logic [RA_W-1:0] r_rd_addr;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic            r_alu_src;
    logic            r_reg_write;
    logic            r_mem_read;

    logic            w_ex_hit1;
    logic            w_ex_hit2;
    logic            w_wb_hit1;
    logic            w_wb_hit2;
    logic [XLEN-1:0] w_fwd1;
    logic [XLEN-1:0] w_fwd2;
    logic            w_uses_rs1;
    logic            w_uses_rs2;
    logic            w_load_use;

    // EX/MEM only forwards while the EX slot is real; rd==0 never forwards.
    always_comb begin
        w_ex_hit1 = r_valid & exmem_reg_write & (exmem_rd != '0) & (exmem_rd == r_rs1_addr);
        w_ex_hit2 = r_valid & exmem_reg_write & (exmem_rd != '0) & (exmem_rd == r_rs2_addr);
        w_wb_hit1 = memwb_reg_write & (memwb_rd != '0) & (memwb_rd == r_rs1_addr);
        w_wb_hit2 = memwb_reg_write & (memwb_rd != '0) & (memwb_rd == r_rs2_addr);

        w_fwd1 = r_rs1_data;
        if (w_ex_hit1)      w_fwd1 = exmem_result;
        else if (w_wb_hit1) w_fwd1 = memwb_result;

        w_fwd2 = r_rs2_data;
        if (w_ex_hit2)      w_fwd2 = exmem_result;
        else if (w_wb_hit2) w_fwd2 = memwb_result;
    end

    always_comb begin
        w_uses_rs1 = (id_opcode != c_op_lui) && (id_opcode != c_op_auipc) &&
                     (id_opcode != c_op_jal);
        w_uses_rs2 = (id_opcode == c_op_rtype) || (id_opcode == c_op_store) ||
                     (id_opcode == c_op_branch);
        w_load_use = r_valid & r_mem_read & (r_rd_addr != '0) & id_valid &
                     ((w_uses_rs1 & (id_rs1_addr == r_rd_addr)) |
                      (w_uses_rs2 & (id_rs2_addr == r_rd_addr)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_opcode    <= '0;
            r_func3     <= '0;
            r_rs1_addr  <= '0;
            r_rs2_addr  <= '0;
            r_rd_addr   <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
            r_alu_src   <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
        end else if (flush || (!stall_in && w_load_use)) begin
            r_valid     <= 1'b0;
            r_opcode    <= '0;
            r_func3     <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
        end else if (stall_in) begin
            // Refresh operands so a value retiring from MEM/WB during the hold survives.
            r_rs1_data  <= w_fwd1;
            r_rs2_data  <= w_fwd2;
        end else begin
            r_valid     <= id_valid;
            r_opcode    <= id_opcode;
            r_func3     <= id_func3;
            r_rs1_addr  <= id_rs1_addr;
            r_rs2_addr  <= id_rs2_addr;
            r_rd_addr   <= id_rd_addr;
            r_rs1_data  <= id_rs1_data;
            r_rs2_data  <= id_rs2_data;
            r_imm       <= id_imm;
            r_alu_src   <= id_alu_src;
            r_reg_write <= id_reg_write;
            r_mem_read  <= id_mem_read;
        end
    end

    always_comb begin
        ex_valid      = r_valid;
        ex_opcode     = r_opcode;
        ex_func3      = r_func3;
        ex_rd_addr    = r_rd_addr;
        ex_reg_write  = r_reg_write;
        ex_mem_read   = r_mem_read;
        ex_store_data = w_fwd2;
        op1           = r_valid ? w_fwd1 : '0;
        op2           = r_valid ? (r_alu_src ? r_imm : w_fwd2) : '0;
        id_stall      = (w_load_use | stall_in) & ~flush;
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_operand_stage
//  Brief    : Self-checking bench for ex_operand_stage (vector table with
//             scoreboard queue plus hand-written hazard sequences).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ex_operand_stage;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    logic            clk;
    logic            rst;
    logic            id_valid;
    logic [6:0]      id_opcode;
    logic [2:0]      id_func3;
    logic [RA_W-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm;
    logic            id_alu_src, id_reg_write, id_mem_read;
    logic            stall_in, flush;
    logic            exmem_reg_write;
    logic [RA_W-1:0] exmem_rd;
    logic [XLEN-1:0] exmem_result;
    logic            memwb_reg_write;
    logic [RA_W-1:0] memwb_rd;
    logic [XLEN-1:0] memwb_result;
    logic            ex_valid;
    logic [XLEN-1:0] op1, op2, ex_store_data;
    logic [6:0]      ex_opcode;
    logic [2:0]      ex_func3;
    logic [RA_W-1:0] ex_rd_addr;
    logic            ex_reg_write, ex_mem_read, id_stall;

    int checks = 0;
    int errors = 0;

    ex_operand_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_opcode(id_opcode), .id_func3(id_func3),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .stall_in(stall_in), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .op1(op1), .op2(op2),
        .ex_opcode(ex_opcode), .ex_func3(ex_func3), .ex_rd_addr(ex_rd_addr),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_store_data(ex_store_data), .id_stall(id_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [6:0]  opcode;
        logic [2:0]  func3;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic        alu_src, rw, mr;
        logic        xw;
        logic [4:0]  xrd;
        logic [31:0] xres;
        logic        ww;
        logic [4:0]  wrd;
        logic [31:0] wres;
        logic [31:0] e_op1, e_op2, e_sd;
    } vec_t;

    vec_t vecs[10];
    vec_t sb[$];

    function automatic vec_t mk(
        input logic v, input logic [6:0] opc, input logic [2:0] f3,
        input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad,
        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
        input logic src, input logic rw, input logic mr,
        input logic xw, input logic [4:0] xrd, input logic [31:0] xres,
        input logic ww, input logic [4:0] wrd, input logic [31:0] wres,
        input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] es);
        vec_t r;
        r.valid = v; r.opcode = opc; r.func3 = f3;
        r.rs1 = a1; r.rs2 = a2; r.rd = ad;
        r.d1 = d1; r.d2 = d2; r.imm = imm;
        r.alu_src = src; r.rw = rw; r.mr = mr;
        r.xw = xw; r.xrd = xrd; r.xres = xres;
        r.ww = ww; r.wrd = wrd; r.wres = wres;
        r.e_op1 = e1; r.e_op2 = e2; r.e_sd = es;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fwd_off();
        exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_opcode = '0; id_func3 = '0;
        id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0;
        id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
        id_alu_src = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0;
        stall_in = 1'b0; flush = 1'b0;
        fwd_off();
    endtask

    task automatic drive_id(input vec_t v);
        id_valid = v.valid; id_opcode = v.opcode; id_func3 = v.func3;
        id_rs1_addr = v.rs1; id_rs2_addr = v.rs2; id_rd_addr = v.rd;
        id_rs1_data = v.d1; id_rs2_data = v.d2; id_imm = v.imm;
        id_alu_src = v.alu_src; id_reg_write = v.rw; id_mem_read = v.mr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t xor_i, lw_i, and_i, add_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        xor_i = mk(1, 7'b0110011, 3'b100, 1, 2, 3, 32'h0000_00F0, 32'h0000_0F0F, 0,
                   0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0000_00F0, 32'h0000_0F0F, 32'h0000_0F0F);
        vecs[0] = xor_i;
        vecs[1] = mk(1, 7'b0010011, 3'b110, 1, 4, 3, 32'h11, 32'h44, 32'hFFFF_FF00,
                     1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h11, 32'hFFFF_FF00, 32'h44);
        vecs[2] = mk(1, 7'b0010011, 3'b110, 1, 4, 3, 32'h11, 32'h44, 32'hFFFF_FF00,
                     1, 1, 0, 1, 1, 32'h1234, 1, 1, 32'h5678, 32'h1234, 32'hFFFF_FF00, 32'h44);
        vecs[3] = mk(1, 7'b0010011, 3'b110, 1, 4, 3, 32'h11, 32'h44, 32'hFFFF_FF00,
                     1, 1, 0, 0, 0, 0, 1, 1, 32'h5678, 32'h5678, 32'hFFFF_FF00, 32'h44);
        vecs[4] = mk(1, 7'b0010011, 3'b110, 0, 4, 3, 32'h0, 32'h44, 32'hFFFF_FF00,
                     1, 1, 0, 1, 0, 32'h1234, 1, 0, 32'h5678, 32'h0, 32'hFFFF_FF00, 32'h44);
        vecs[5] = mk(1, 7'b0010011, 3'b110, 1, 4, 3, 32'h11, 32'h44, 32'hFFFF_FF00,
                     1, 1, 0, 0, 1, 32'h1234, 0, 1, 32'h5678, 32'h11, 32'hFFFF_FF00, 32'h44);
        vecs[6] = mk(1, 7'b0110011, 3'b000, 1, 2, 7, 32'h10, 32'h20, 0,
                     0, 1, 0, 1, 2, 32'hCAFE_0000, 1, 1, 32'h77, 32'h77, 32'hCAFE_0000, 32'hCAFE_0000);
        vecs[7] = mk(1, 7'b0100011, 3'b010, 1, 2, 0, 32'h100, 32'h5, 32'h8,
                     1, 0, 0, 0, 0, 0, 1, 2, 32'hBEEF, 32'h100, 32'h8, 32'hBEEF);
        vecs[8] = mk(0, 7'b0110011, 3'b111, 1, 2, 4, 32'h1, 32'h2, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h2);
        vecs[9] = mk(1, 7'b0000011, 3'b010, 1, 0, 9, 32'h2000, 32'h0, 32'h10,
                     1, 1, 1, 0, 0, 0, 0, 0, 0, 32'h2000, 32'h10, 32'h0);
        lw_i  = mk(1, 7'b0000011, 3'b010, 1, 0, 5, 32'h3000, 0, 32'h4,
                   1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        and_i = mk(1, 7'b0110011, 3'b111, 5, 7, 6, 32'h0, 32'h0F0F_0F0F, 0,
                   0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_i = mk(1, 7'b0110011, 3'b000, 3, 2, 8, 32'h33, 32'h0, 0,
                   0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Power-up reset, then reset again while a valid instruction is in EX.
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        drive_id(xor_i);
        tick();
        chk("pre_reset_valid", 32'(ex_valid), 32'd1);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            id_valid = 1'b1;
            id_opcode = 7'($urandom); id_func3 = 3'($urandom);
            id_rs1_addr = 5'($urandom); id_rs2_addr = 5'($urandom); id_rd_addr = 5'($urandom);
            id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
            id_alu_src = 1'($urandom); id_reg_write = 1'($urandom); id_mem_read = 1'($urandom);
            exmem_reg_write = 1'b1; exmem_rd = 5'($urandom); exmem_result = $urandom;
            memwb_reg_write = 1'b1; memwb_rd = 5'($urandom); memwb_result = $urandom;
            tick();
            chk("rst_valid", 32'(ex_valid), 0);
            chk("rst_op1", op1, 0);
            chk("rst_op2", op2, 0);
            chk("rst_store", ex_store_data, 0);
            chk("rst_opcode", 32'(ex_opcode), 0);
            chk("rst_func3", 32'(ex_func3), 0);
            chk("rst_rd", 32'(ex_rd_addr), 0);
            chk("rst_regwrite", 32'(ex_reg_write), 0);
            chk("rst_memread", 32'(ex_mem_read), 0);
            chk("rst_id_stall", 32'(id_stall), 0);
        end
        rst = 1'b0;
        idle();
        tick();

        // Table vectors: expectations are queued at drive time, popped at EX.
        for (int i = 0; i < 10; i++) begin
            vec_t e;
            fwd_off();
            drive_id(vecs[i]);
            sb.push_back(vecs[i]);
            tick();
            id_valid = 1'b0;
            exmem_reg_write = vecs[i].xw; exmem_rd = vecs[i].xrd; exmem_result = vecs[i].xres;
            memwb_reg_write = vecs[i].ww; memwb_rd = vecs[i].wrd; memwb_result = vecs[i].wres;
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d_valid", i), 32'(ex_valid), 32'(e.valid));
            chk($sformatf("v%0d_op1", i), op1, e.e_op1);
            chk($sformatf("v%0d_op2", i), op2, e.e_op2);
            chk($sformatf("v%0d_store", i), ex_store_data, e.e_sd);
            chk($sformatf("v%0d_opcode", i), 32'(ex_opcode), 32'(e.opcode));
            chk($sformatf("v%0d_func3", i), 32'(ex_func3), 32'(e.func3));
            chk($sformatf("v%0d_rd", i), 32'(ex_rd_addr), 32'(e.rd));
            chk($sformatf("v%0d_regwrite", i), 32'(ex_reg_write), 32'(e.rw));
            chk($sformatf("v%0d_memread", i), 32'(ex_mem_read), 32'(e.mr));
        end
        idle();
        tick();

        // Load-use: LW x5 in EX, AND x6,x5,x7 in ID.
        drive_id(lw_i);
        tick();
        drive_id(and_i);
        #1;
        chk("lu_id_stall", 32'(id_stall), 1);
        tick();
        chk("lu_bubble_valid", 32'(ex_valid), 0);
        chk("lu_bubble_memread", 32'(ex_mem_read), 0);
        chk("lu_stall_released", 32'(id_stall), 0);
        tick();
        memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_result = 32'hDEAD_BEEF;
        id_valid = 1'b0;
        #1;
        chk("lu_and_valid", 32'(ex_valid), 1);
        chk("lu_and_op1", op1, 32'hDEAD_BEEF);
        chk("lu_and_op2", op2, 32'h0F0F_0F0F);
        chk("lu_and_rd", 32'(ex_rd_addr), 32'd6);
        idle();
        tick();

        // Downstream hold for 3 cycles while MEM/WB retires x2 on the first.
        drive_id(add_i);
        tick();
        drive_id(xor_i);
        id_rd_addr = 5'd12;
        stall_in = 1'b1;
        memwb_reg_write = 1'b1; memwb_rd = 5'd2; memwb_result = 32'hA5A5_A5A5;
        #1;
        chk("hold_id_stall", 32'(id_stall), 1);
        chk("hold_op2_fwd", op2, 32'hA5A5_A5A5);
        for (int h = 0; h < 3; h++) begin
            tick();
            fwd_off();
            #1;
            chk($sformatf("hold%0d_op2", h), op2, 32'hA5A5_A5A5);
            chk($sformatf("hold%0d_store", h), ex_store_data, 32'hA5A5_A5A5);
            chk($sformatf("hold%0d_op1", h), op1, 32'h33);
            chk($sformatf("hold%0d_rd", h), 32'(ex_rd_addr), 32'd8);
            chk($sformatf("hold%0d_valid", h), 32'(ex_valid), 1);
        end
        stall_in = 1'b0;
        tick();
        chk("hold_release_rd", 32'(ex_rd_addr), 32'd12);
        chk("hold_release_func3", 32'(ex_func3), 32'd4);
        idle();
        tick();

        // stall_in together with load-use: hold, no bubble, then bubble once released.
        drive_id(lw_i);
        tick();
        drive_id(and_i);
        stall_in = 1'b1;
        #1;
        chk("slu_id_stall", 32'(id_stall), 1);
        tick();
        chk("slu_held_valid", 32'(ex_valid), 1);
        chk("slu_held_memread", 32'(ex_mem_read), 1);
        chk("slu_held_rd", 32'(ex_rd_addr), 32'd5);
        stall_in = 1'b0;
        #1;
        chk("slu_lu_stall", 32'(id_stall), 1);
        tick();
        chk("slu_bubble_valid", 32'(ex_valid), 0);
        idle();
        tick();

        // flush and stall_in together: flush wins.
        drive_id(xor_i);
        tick();
        chk("fl_pre_valid", 32'(ex_valid), 1);
        drive_id(add_i);
        flush = 1'b1;
        stall_in = 1'b1;
        #1;
        chk("fl_id_stall", 32'(id_stall), 0);
        tick();
        chk("fl_valid", 32'(ex_valid), 0);
        chk("fl_regwrite", 32'(ex_reg_write), 0);
        chk("fl_opcode", 32'(ex_opcode), 0);
        chk("fl_op1", op1, 0);
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
